// File: rtl/cpu_csr_pkg.sv
// Shared definitions for the Zicsr execution block: CSR addresses, funct3
// encodings, FSM states and the implemented-CSR membership test.
package cpu_csr_pkg;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic [2:0] {
    F3_RSVD0  = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_RSVD4  = 3'b100,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic logic is_impl_csr(input logic [11:0] addr);
    case (addr)
      CSR_CYCLE, CSR_CYCLEH, CSR_TIME,
      CSR_TIMEH, CSR_INSTRET, CSR_INSTRETH: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_csr_alu.sv
// Read-modify-write datapath for the Zicsr instructions: produces the new
// CSR value from the old value and the (register or immediate) operand.
module cpu_csr_alu
  import cpu_csr_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] old_i,
  input  logic [31:0] operand_i,
  output logic [31:0] new_o
);

  always_comb begin
    // NOTE: default first so every path assigns new_o and no latch is inferred.
    new_o = old_i;
    case (funct3_e'(funct3_i))
      F3_CSRRW, F3_CSRRWI: new_o = operand_i;
      F3_CSRRS, F3_CSRRSI: new_o = old_i | operand_i;
      F3_CSRRC, F3_CSRRCI: new_o = old_i & ~operand_i;
      default:             new_o = old_i;
    endcase
  end

endmodule

// File: rtl/cpu_csr_exec.sv
// Zicsr execution FSM: latches a request, reads the CSR, computes and writes
// the new value, and reports done/illegal/retire three cycles after start.
module cpu_csr_exec
  import cpu_csr_pkg::*;
#(
  // One extra writable CSR the attached CSR file may implement.
  parameter logic [11:0] EXTRA_CSR_ADDR = CSR_CYCLE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_val,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [31:0] rd_val,
  output logic        retire,
  output logic [11:0] csr_addr_o,
  input  logic [31:0] csr_rdata,
  output logic [31:0] csr_wdata,
  output logic        csr_wr
);

  state_e      state_q;
  logic [2:0]  funct3_q;
  logic [11:0] addr_q;
  logic [4:0]  rs1_idx_q;
  logic [31:0] rs1_val_q;
  logic [31:0] rd_val_q;
  logic [31:0] wdata_q;
  logic        illegal_q;
  logic        wr_en_q;

  logic [31:0] operand;
  logic [31:0] wdata_d;
  logic        wr_intent;
  logic        illegal_d;

  assign operand   = funct3_q[2] ? {27'd0, rs1_idx_q} : rs1_val_q;
  // Set/clear forms with rs1/uimm of zero are pure reads.
  assign wr_intent = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
  assign illegal_d = (funct3_q[1:0] == 2'b00)
                  || !(is_impl_csr(addr_q) || (addr_q == EXTRA_CSR_ADDR))
                  || (wr_intent && (addr_q[11:10] == 2'b11));

  cpu_csr_alu u_alu (
    .funct3_i  (funct3_q),
    .old_i     (csr_rdata),
    .operand_i (operand),
    .new_o     (wdata_d)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q   <= ST_IDLE;
      funct3_q  <= 3'd0;
      addr_q    <= 12'd0;
      rs1_idx_q <= 5'd0;
      rs1_val_q <= 32'd0;
      rd_val_q  <= 32'd0;
      wdata_q   <= 32'd0;
      illegal_q <= 1'b0;
      wr_en_q   <= 1'b0;
    end else if (kill) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          funct3_q  <= funct3;
          addr_q    <= csr_addr;
          rs1_idx_q <= rs1_idx;
          rs1_val_q <= rs1_val;
          state_q   <= ST_READ;
        end
        ST_READ: begin
          rd_val_q  <= csr_rdata;
          wdata_q   <= wdata_d;
          illegal_q <= illegal_d;
          wr_en_q   <= wr_intent && !illegal_d;
          state_q   <= ST_WRITE;
        end
        ST_WRITE: state_q <= ST_DONE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // kill must suppress the strobes in the very cycle it is seen.
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE) && !kill;
  assign retire     = done && !illegal_q;
  assign csr_wr     = (state_q == ST_WRITE) && wr_en_q && !kill;
  assign illegal    = illegal_q;
  assign rd_val     = rd_val_q;
  assign csr_wdata  = wdata_q;
  assign csr_addr_o = addr_q;

endmodule

// File: tb/tb_cpu_csr_exec.sv
// Directed self-checking bench for cpu_csr_exec with a small CSR-file read model.
module tb_cpu_csr_exec;
  import cpu_csr_pkg::*;

  localparam logic [11:0] RW_ADDR = 12'h340;
  localparam logic [31:0] RW_OLD  = 32'hF0F0_00FF;

  logic        clk, rst, start, kill;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_val;
  logic        busy, done, illegal, retire, csr_wr;
  logic [31:0] rd_val, csr_rdata, csr_wdata;
  logic [11:0] csr_addr_o;

  int total = 0;
  int bad   = 0;

  // Per-run observations, index k = cycles elapsed after the start edge.
  int          done_at, wr_cnt, retire_cnt;
  logic [31:0] wr_data, obs_rd;
  logic        obs_ill, addr_bad;
  logic        busy_at [1:6];

  cpu_csr_exec #(.EXTRA_CSR_ADDR(RW_ADDR)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .csr_addr(csr_addr),
    .rs1_idx(rs1_idx), .rs1_val(rs1_val), .kill(kill), .busy(busy), .done(done),
    .illegal(illegal), .rd_val(rd_val), .retire(retire), .csr_addr_o(csr_addr_o),
    .csr_rdata(csr_rdata), .csr_wdata(csr_wdata), .csr_wr(csr_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (csr_addr_o)
      CSR_CYCLE:   csr_rdata = 32'h0000_0123;
      CSR_TIMEH:   csr_rdata = 32'h0000_0ABC;
      CSR_INSTRET: csr_rdata = 32'h0000_0055;
      RW_ADDR:     csr_rdata = RW_OLD;
      default:     csr_rdata = 32'h0;
    endcase
  end

  task automatic run(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                     input logic [31:0] v, input int kill_at, input int rst_at,
                     input logic pulse_busy);
    @(negedge clk);
    funct3 = f3; csr_addr = a; rs1_idx = idx; rs1_val = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0; funct3 = 3'b000; csr_addr = 12'hFFF; rs1_idx = 5'h1F; rs1_val = '1;
    done_at = 0; wr_cnt = 0; retire_cnt = 0; wr_data = 0; obs_rd = 0; obs_ill = 0;
    addr_bad = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k == kill_at) kill = 1'b1;
      if (k == rst_at) begin rst = 1'b1; start = 1'b1; end
      if (pulse_busy && k <= 3) start = 1'b1;
      #1;
      busy_at[k] = busy;
      if (k <= 3 && busy && csr_addr_o !== a) addr_bad = 1'b1;
      if (done && done_at == 0) begin done_at = k; obs_ill = illegal; obs_rd = rd_val; end
      if (retire) retire_cnt++;
      if (csr_wr) begin wr_cnt++; wr_data = csr_wdata; end
      @(negedge clk);
      kill = 1'b0; rst = 1'b0; start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (retire !== 1'b0)      begin bad++; $display("FAIL rst_retire got=%b exp=0", retire); end
    total++; if (csr_wr !== 1'b0)      begin bad++; $display("FAIL rst_csr_wr got=%b exp=0", csr_wr); end
    total++; if (illegal !== 1'b0)     begin bad++; $display("FAIL rst_illegal got=%b exp=0", illegal); end
    total++; if (rd_val !== 32'd0)     begin bad++; $display("FAIL rst_rd_val got=%h exp=0", rd_val); end
    total++; if (csr_wdata !== 32'd0)  begin bad++; $display("FAIL rst_wdata got=%h exp=0", csr_wdata); end
    total++; if (csr_addr_o !== 12'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", csr_addr_o); end
    rst = 1'b0;
  endtask

  task automatic test_read_only_ops;
    // CSRRS cycle, rs1=x0: pure read
    run(F3_CSRRS, CSR_CYCLE, 5'd0, 32'hFFFF_FFFF, 0, 0, 1'b0);
    total++; if (done_at !== 3)         begin bad++; $display("FAIL rs_done_at got=%0d exp=3", done_at); end
    total++; if (obs_rd !== 32'h123)    begin bad++; $display("FAIL rs_rd_val got=%h exp=123", obs_rd); end
    total++; if (obs_ill !== 1'b0)      begin bad++; $display("FAIL rs_illegal got=%b exp=0", obs_ill); end
    total++; if (wr_cnt !== 0)          begin bad++; $display("FAIL rs_wr got=%0d exp=0", wr_cnt); end
    total++; if (retire_cnt !== 1)      begin bad++; $display("FAIL rs_retire got=%0d exp=1", retire_cnt); end
    total++; if (busy_at[4] !== 1'b0)   begin bad++; $display("FAIL rs_idle_after got=%b exp=0", busy_at[4]); end
    total++; if (addr_bad !== 1'b0)     begin bad++; $display("FAIL rs_addr_hold got=%b exp=0", addr_bad); end
    total++; if (rd_val !== 32'h123)    begin bad++; $display("FAIL rs_rd_hold got=%h exp=123", rd_val); end
    // CSRRCI timeh, uimm 0
    run(F3_CSRRCI, CSR_TIMEH, 5'd0, 32'h0, 0, 0, 1'b0);
    total++; if (obs_ill !== 1'b0)      begin bad++; $display("FAIL rci_illegal got=%b exp=0", obs_ill); end
    total++; if (obs_rd !== 32'hABC)    begin bad++; $display("FAIL rci_rd_val got=%h exp=abc", obs_rd); end
    total++; if (wr_cnt !== 0)          begin bad++; $display("FAIL rci_wr got=%0d exp=0", wr_cnt); end
    total++; if (retire_cnt !== 1)      begin bad++; $display("FAIL rci_retire got=%0d exp=1", retire_cnt); end
  endtask

  task automatic test_illegal;
    run(F3_CSRRW, CSR_INSTRET, 5'd3, 32'hDEAD_BEEF, 0, 0, 1'b0);
    total++; if (done_at !== 3)         begin bad++; $display("FAIL rw_ro_done_at got=%0d exp=3", done_at); end
    total++; if (obs_ill !== 1'b1)      begin bad++; $display("FAIL rw_ro_illegal got=%b exp=1", obs_ill); end
    total++; if (wr_cnt !== 0)          begin bad++; $display("FAIL rw_ro_wr got=%0d exp=0", wr_cnt); end
    total++; if (retire_cnt !== 0)      begin bad++; $display("FAIL rw_ro_retire got=%0d exp=0", retire_cnt); end
    total++; if (illegal !== 1'b1)      begin bad++; $display("FAIL rw_ro_ill_hold got=%b exp=1", illegal); end
    run(F3_CSRRS, 12'h300, 5'd0, 32'h0, 0, 0, 1'b0);
    total++; if (obs_ill !== 1'b1)      begin bad++; $display("FAIL unimpl_illegal got=%b exp=1", obs_ill); end
    total++; if (retire_cnt !== 0)      begin bad++; $display("FAIL unimpl_retire got=%0d exp=0", retire_cnt); end
    run(F3_CSRRSI, CSR_CYCLE, 5'd4, 32'h0, 0, 0, 1'b0);
    total++; if (obs_ill !== 1'b1)      begin bad++; $display("FAIL rsi_ro_illegal got=%b exp=1", obs_ill); end
    run(F3_RSVD4, RW_ADDR, 5'd1, 32'h1, 0, 0, 1'b0);
    total++; if (obs_ill !== 1'b1)      begin bad++; $display("FAIL f3_100_illegal got=%b exp=1", obs_ill); end
    total++; if (wr_cnt !== 0)          begin bad++; $display("FAIL f3_100_wr got=%0d exp=0", wr_cnt); end
    total++; if (retire_cnt !== 0)      begin bad++; $display("FAIL f3_100_retire got=%0d exp=0", retire_cnt); end
  endtask

  task automatic test_writes;
    logic [2:0]  f3   [6] = '{F3_CSRRW, F3_CSRRS, F3_CSRRC, F3_CSRRWI, F3_CSRRCI, F3_CSRRS};
    logic [4:0]  idx  [6] = '{5'd2, 5'd1, 5'd9, 5'h15, 5'h1F, 5'd0};
    logic [31:0] val  [6] = '{32'h1234_5678, 32'h0F00_0F00, 32'h0000_00F0,
                              32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_FFFF};
    logic [31:0] expw [6] = '{32'h1234_5678, 32'hFFF0_0FFF, 32'hF0F0_000F,
                              32'h0000_0015, 32'hF0F0_00E0, 32'h0};
    int          expn [6] = '{1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      run(f3[i], RW_ADDR, idx[i], val[i], 0, 0, 1'b0);
      total++; if (wr_cnt !== expn[i])  begin bad++; $display("FAIL wr%0d_count got=%0d exp=%0d", i, wr_cnt, expn[i]); end
      if (expn[i] == 1) begin
        total++; if (wr_data !== expw[i]) begin bad++; $display("FAIL wr%0d_data got=%h exp=%h", i, wr_data, expw[i]); end
      end
      total++; if (obs_rd !== RW_OLD)   begin bad++; $display("FAIL wr%0d_rd_val got=%h exp=%h", i, obs_rd, RW_OLD); end
      total++; if (retire_cnt !== 1)    begin bad++; $display("FAIL wr%0d_retire got=%0d exp=1", i, retire_cnt); end
    end
  endtask

  task automatic test_kill;
    run(F3_CSRRW, RW_ADDR, 5'd2, 32'hCAFE_F00D, 2, 0, 1'b0);
    total++; if (wr_cnt !== 0)          begin bad++; $display("FAIL kill_wr got=%0d exp=0", wr_cnt); end
    total++; if (busy_at[3] !== 1'b0)   begin bad++; $display("FAIL kill_idle got=%b exp=0", busy_at[3]); end
    total++; if (done_at !== 0)         begin bad++; $display("FAIL kill_done got=%0d exp=0", done_at); end
    total++; if (retire_cnt !== 0)      begin bad++; $display("FAIL kill_retire got=%0d exp=0", retire_cnt); end
    run(F3_CSRRW, RW_ADDR, 5'd2, 32'h1, 3, 0, 1'b0);
    total++; if (done_at !== 0)         begin bad++; $display("FAIL kill_done_state got=%0d exp=0", done_at); end
    total++; if (retire_cnt !== 0)      begin bad++; $display("FAIL kill_done_retire got=%0d exp=0", retire_cnt); end
    @(negedge clk);
    funct3 = F3_CSRRS; csr_addr = CSR_CYCLE; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    #1;
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL kill_start_idle got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    run(F3_CSRRW, RW_ADDR, 5'd2, 32'h5555_AAAA, 0, 1, 1'b0);
    total++; if (busy_at[2] !== 1'b0)   begin bad++; $display("FAIL rst_abort_busy got=%b exp=0", busy_at[2]); end
    total++; if (wr_cnt !== 0)          begin bad++; $display("FAIL rst_abort_wr got=%0d exp=0", wr_cnt); end
    total++; if (retire_cnt !== 0)      begin bad++; $display("FAIL rst_abort_retire got=%0d exp=0", retire_cnt); end
    run(F3_CSRRW, RW_ADDR, 5'd2, 32'h0000_A5A5, 0, 0, 1'b1);
    total++; if (done_at !== 3)         begin bad++; $display("FAIL fresh_done_at got=%0d exp=3", done_at); end
    total++; if (wr_cnt !== 1)          begin bad++; $display("FAIL fresh_wr got=%0d exp=1", wr_cnt); end
    total++; if (wr_data !== 32'hA5A5)  begin bad++; $display("FAIL fresh_wdata got=%h exp=a5a5", wr_data); end
    total++; if (busy_at[4] !== 1'b0)   begin bad++; $display("FAIL busy_pulse_idle4 got=%b exp=0", busy_at[4]); end
    total++; if (busy_at[5] !== 1'b0)   begin bad++; $display("FAIL busy_pulse_idle5 got=%b exp=0", busy_at[5]); end
    total++; if (retire_cnt !== 1)      begin bad++; $display("FAIL fresh_retire got=%0d exp=1", retire_cnt); end
  endtask

  initial begin
    start = 1'b0; kill = 1'b0; rst = 1'b1;
    funct3 = 3'd0; csr_addr = 12'd0; rs1_idx = 5'd0; rs1_val = 32'd0;
    test_reset();
    test_read_only_ops();
    test_illegal();
    test_writes();
    test_kill();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
